ahb_data_slave: RTL

AHB-Lite style slave that sits directly downstream of the RV32I core's data-memory bus master port and serves its transfers. It decodes the core's address/control phase, inserts a programmable number of wait states, and performs byte/half/word accesses on an internal word-addressed SRAM. It returns read data and an OKAY/ERROR response on PRDATA_A/PREADY_A/PRESP_A. Ports connect one-to-one with the core's bus signals.

---
 rtl/ahb_data_slave.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_data_slave.sv
// AHB-Lite data-memory slave: programmable wait states, byte/half/word access to a word SRAM.
// Optional macro AHB_SLV_ERR_EN builds the two-cycle ERR1/ERR2 ERROR response for illegal transfers.
module ahb_data_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PADDR_A,
    input  logic        PWRITE_A,
    input  logic [1:0]  PSIZE_A,
    input  logic [1:0]  PTRANS_A,
    input  logic [2:0]  PBURST_A,
    input  logic [31:0] PWDATA_A,
    output logic [31:0] PRDATA_A,
    output logic        PREADY_A,
    output logic        PRESP_A
);
    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_CYCLES);
    localparam bit          HAS_WAIT     = (WAIT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2
`ifdef AHB_SLV_ERR_EN
        , ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic [3:0]       lanes_q, lanes_d;
    logic             err_q, err_d;

    logic [31:0]      offset;
    logic             in_range;
    logic             misalign;
    logic [3:0]       bus_lanes;
    logic             bus_err;
    logic [IDX_W-1:0] bus_idx;
    logic             accept;

    logic             rd_en;
    logic             rd_zero;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_commit;
    logic             unused_bits;

    // Address-phase decode; subtraction first so a window near the top of memory cannot wrap.
    assign offset   = PADDR_A - BASE_ADDR;
    assign in_range = (PADDR_A >= BASE_ADDR) && (offset < WINDOW_BYTES);
    assign bus_idx  = offset[IDX_W+1:2];
    assign bus_err  = !in_range || misalign;
    assign accept   = PREADY_A && PTRANS_A[1];

    assign unused_bits = ^{PBURST_A, PTRANS_A[0], offset[31:IDX_W+2], offset[1:0]};

    always_comb begin
        bus_lanes = 4'b0000;
        misalign  = 1'b0;
        case (PSIZE_A)
            2'b00: bus_lanes = 4'b0001 << PADDR_A[1:0];
            2'b01: begin
                bus_lanes = PADDR_A[1] ? 4'b1100 : 4'b0011;
                misalign  = PADDR_A[0];
            end
            2'b10: begin
                bus_lanes = 4'b1111;
                misalign  = |PADDR_A[1:0];
            end
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        lanes_d = lanes_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        rd_zero = err_q;
        if (accept) begin
            idx_d   = bus_idx;
            write_d = PWRITE_A;
            lanes_d = bus_lanes;
            err_d   = bus_err;
`ifdef AHB_SLV_ERR_EN
            if (bus_err) begin
                state_d = ST_ERR1;
            end else
`endif
            if (HAS_WAIT) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_INIT;
            end else begin
                // Zero-wait read: the SRAM is read with the live bus address on the accept edge.
                state_d = ST_DATA;
                rd_en   = !PWRITE_A;
                rd_idx  = bus_idx;
                rd_zero = bus_err;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DATA;
                        cnt_d   = 4'd0;
                        rd_en   = !write_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
`ifdef AHB_SLV_ERR_EN
                ST_ERR1: state_d = ST_ERR2;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            lanes_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            lanes_q <= lanes_d;
            err_q   <= err_d;
        end
    end

`ifdef AHB_SLV_ERR_EN
    assign PREADY_A = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign PRESP_A  = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign PREADY_A = (state_q == ST_IDLE) || (state_q == ST_DATA);
    assign PRESP_A  = 1'b0;
`endif

    // Illegal transfers never touch storage; a reset edge also suppresses the write.
    assign wr_commit = (state_q == ST_DATA) && write_q && !err_q && !rst;

    // One byte-wide SRAM per lane; a same-edge write to the read word is forwarded lane by lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_byte_q;
        logic [7:0] wr_byte;
        logic       wr_en;

        assign wr_byte = PWDATA_A[8*gi +: 8];
        assign wr_en   = wr_commit && lanes_q[gi];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[idx_q] <= wr_byte;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_byte_q <= 8'h00;
            end else if (rd_en) begin
                if (rd_zero) begin
                    rd_byte_q <= 8'h00;
                end else if (wr_en && (idx_q == rd_idx)) begin
                    rd_byte_q <= wr_byte;
                end else begin
                    rd_byte_q <= mem[rd_idx];
                end
            end
        end

        assign PRDATA_A[8*gi +: 8] = rd_byte_q;
    end
endmodule
